// File: rtl/spi_host_pkg.sv
// Shared types and constants for the SPI image host.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        XFER  = 3'd2,
        LABEL = 3'd3,
        WAIT  = 3'd4,
        RESP  = 3'd5,
        GAP   = 3'd6
    } state_e;

    localparam int         RESP_BYTES = 2;
    localparam logic [3:0] NO_LABEL   = 4'hF;
    localparam int         BYTE_W     = 8;

endpackage

// File: rtl/spi_byte_shifter.sv
// One mode-0 SPI byte: SCK divider, MSB-first TX shifter, RX shifter and bit counter.
module spi_byte_shifter
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load,
    input  logic [BYTE_W-1:0] tx_byte,
    input  logic              go,
    input  logic              miso,
    output logic              byte_done,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              sck,
    output logic              mosi
);

    localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
    localparam int               BIT_W    = $clog2(BYTE_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              sck_q, sck_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              tick_s;

    // Divider and shifters; the last falling edge also empties TX so MOSI idles low.
    always_comb begin
        div_d     = div_q;
        sck_d     = sck_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_d     = bit_q;
        tick_s    = go && (div_q == DIV_LAST);
        byte_done = tick_s && sck_q && (bit_q == BIT_LAST);
        if (load) begin
            div_d = {DIV_W{1'b0}};
            sck_d = 1'b0;
            tx_d  = tx_byte;
            bit_d = {BIT_W{1'b0}};
        end else if (tick_s) begin
            div_d = {DIV_W{1'b0}};
            sck_d = ~sck_q;
            if (!sck_q) begin
                rx_d = {rx_q[BYTE_W-2:0], miso};
            end else begin
                tx_d  = {tx_q[BYTE_W-2:0], 1'b0};
                bit_d = bit_q + BIT_W'(1);
            end
        end else if (go) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = div_q;
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_q <= {DIV_W{1'b0}};
            sck_q <= 1'b0;
            tx_q  <= {BYTE_W{1'b0}};
            rx_q  <= {BYTE_W{1'b0}};
            bit_q <= {BIT_W{1'b0}};
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            bit_q <= bit_d;
        end
    end

    assign rx_byte = rx_q;
    assign sck     = sck_q;
    assign mosi    = tx_q[BYTE_W-1];

endmodule

// File: rtl/spi_image_host.sv
// Host-side SPI master: streams a pixel frame and label byte, waits, then reads digit and cost.
module spi_image_host
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BYTES = 98,
    parameter int WAIT_CYCLES = 2048
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [3:0]  label,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit,
    output logic [7:0]  cost,
    output logic        SCK,
    output logic        SS,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int BCNT_W = $clog2(FRAME_BYTES + 1);
    localparam int WCNT_W = $clog2(WAIT_CYCLES + 2 * CLK_DIV + 1);
    localparam int RCNT_W = $clog2(RESP_BYTES);

    state_e            state_q, state_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [RCNT_W-1:0] resp_cnt_q, resp_cnt_d;
    logic [3:0]        label_q, label_d;
    logic [3:0]        byte0_q, byte0_d;
    logic [3:0]        digit_q, digit_d;
    logic [7:0]        cost_q, cost_d;
    logic              done_q, done_d;
    logic              ss_q, ss_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              load_s, go_s, byte_done_s;
    logic [BYTE_W-1:0] tx_byte_s, rx_byte_s;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (load_s),
        .tx_byte   (tx_byte_s),
        .go        (go_s),
        .miso      (MISO),
        .byte_done (byte_done_s),
        .rx_byte   (rx_byte_s),
        .sck       (SCK),
        .mosi      (MOSI)
    );

    // Transaction sequencing; label and response bytes are loaded on the previous byte's last edge.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        resp_cnt_d = resp_cnt_q;
        label_d    = label_q;
        byte0_d    = byte0_q;
        digit_d    = digit_q;
        cost_d     = cost_q;
        done_d     = 1'b0;
        load_s     = 1'b0;
        go_s       = 1'b0;
        tx_byte_s  = {BYTE_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    label_d    = label;
                    byte_cnt_d = {BCNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (tx_valid) begin
                    load_s    = 1'b1;
                    tx_byte_s = tx_data;
                    state_d   = XFER;
                end else begin
                    state_d = FETCH;
                end
            end
            XFER: begin
                go_s = 1'b1;
                if (byte_done_s) begin
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    if (byte_cnt_d == BCNT_W'(FRAME_BYTES)) begin
                        load_s    = 1'b1;
                        tx_byte_s = {4'h0, label_q};
                        state_d   = LABEL;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            LABEL: begin
                go_s = 1'b1;
                if (byte_done_s) begin
                    wait_cnt_d = {WCNT_W{1'b0}};
                    state_d    = WAIT;
                end else begin
                    state_d = LABEL;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WCNT_W'(WAIT_CYCLES - 1)) begin
                    load_s     = 1'b1;
                    resp_cnt_d = {RCNT_W{1'b0}};
                    state_d    = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            RESP: begin
                go_s = 1'b1;
                if (byte_done_s && (resp_cnt_q == RCNT_W'(RESP_BYTES - 1))) begin
                    digit_d    = byte0_q;
                    cost_d     = rx_byte_s;
                    wait_cnt_d = {WCNT_W{1'b0}};
                    state_d    = GAP;
                end else if (byte_done_s) begin
                    if (resp_cnt_q == {RCNT_W{1'b0}}) begin
                        byte0_d = rx_byte_s[3:0];
                    end else begin
                        byte0_d = byte0_q;
                    end
                    resp_cnt_d = resp_cnt_q + RCNT_W'(1);
                    load_s     = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            GAP: begin
                done_d = (wait_cnt_q == WCNT_W'(2 * CLK_DIV - 2));
                if (wait_cnt_q == WCNT_W'(2 * CLK_DIV - 1)) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ss_d    = (state_d == IDLE) || (state_d == GAP);
        ready_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= {BCNT_W{1'b0}};
            wait_cnt_q <= {WCNT_W{1'b0}};
            resp_cnt_q <= {RCNT_W{1'b0}};
            label_q    <= 4'h0;
            byte0_q    <= 4'h0;
            digit_q    <= 4'h0;
            cost_q     <= 8'h00;
            done_q     <= 1'b0;
            ss_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            label_q    <= label_d;
            byte0_q    <= byte0_d;
            digit_q    <= digit_d;
            cost_q     <= cost_d;
            done_q     <= done_d;
            ss_q       <= ss_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign digit    = digit_q;
    assign cost     = cost_q;
    assign SS       = ss_q;

endmodule

// File: tb/tb_spi_image_host.sv
// Directed bench for spi_image_host with a mode-0 slave model on MISO and a MOSI/SCK monitor.
module tb_spi_image_host;
    import spi_host_pkg::*;

    localparam int CD         = 2;
    localparam int FB         = 2;
    localparam int WC         = 8;
    localparam int RESP_START = 8 * (FB + 1);

    logic       clk = 1'b0;
    logic       n_rst, start, tx_valid;
    logic [3:0] label;
    logic [7:0] tx_data;
    logic       tx_ready, busy, done, SCK, SS, MOSI, MISO;
    logic [3:0] digit;
    logic [7:0] cost;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] resp_word = 16'h0000;
    logic        prev_sck = 1'b0;
    logic        prev_ss = 1'b1;
    logic        prev_mosi = 1'b0;
    int          fall_cnt = 0;
    int          nbits = 0;
    int          mode0_bad = 0;
    int          done_cnt = 0;
    int          rise_total = 0;
    int          resp_idx;
    logic [63:0] mosi_bits = 64'h0;
    logic [7:0]  frame [FB] = '{8'hA5, 8'h3C};

    spi_image_host #(.CLK_DIV(CD), .FRAME_BYTES(FB), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .label(label),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .digit(digit), .cost(cost),
        .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Bus monitor: MOSI capture on SCK rise, mode-0 stability, done pulses, slave fall counter.
    always @(negedge clk) begin
        prev_sck  <= SCK;
        prev_ss   <= SS;
        prev_mosi <= MOSI;
        if (SS === 1'b1) fall_cnt <= 0;
        else if (!SCK && prev_sck) fall_cnt <= fall_cnt + 1;
        if (!SS && prev_ss) begin
            nbits     <= 0;
            mosi_bits <= 64'h0;
        end else if (SCK && !prev_sck) begin
            mosi_bits  <= {mosi_bits[62:0], MOSI};
            nbits      <= nbits + 1;
            rise_total <= rise_total + 1;
        end
        if (SCK && prev_sck && (MOSI !== prev_mosi)) mode0_bad <= mode0_bad + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Slave shifts its response out after each SCK fall, so bit i is stable before rise RESP_START+i+1.
    assign resp_idx = fall_cnt - RESP_START;
    assign MISO = (resp_idx >= 0 && resp_idx < 16) ? resp_word[15 - resp_idx] : 1'b0;

    task automatic run_txn(input logic [3:0] lbl, input logic [7:0] r0, input logic [7:0] r1,
                           input int stall, input int busy_at, input int abort_at, input int snap_at,
                           output int cycles, output int stall_bad,
                           output logic [3:0] snap_digit, output logic [7:0] snap_cost);
        int bi;
        int stall_left;
        bit hs;
        resp_word  = {r0, r1};
        bi         = 0;
        stall_left = stall;
        stall_bad  = 0;
        hs         = 1'b0;
        snap_digit = 4'h0;
        snap_cost  = 8'h00;
        @(negedge clk);
        start    = 1'b1;
        label    = lbl;
        tx_valid = 1'b1;
        tx_data  = frame[0];
        cycles   = 1;
        while (cycles < 2000) begin
            @(negedge clk);
            cycles++;
            start = (cycles == busy_at);
            if (start) label = 4'd2;
            if (hs) bi++;
            if (cycles == abort_at) return;
            if (cycles == snap_at) begin
                snap_digit = digit;
                snap_cost  = cost;
            end
            if (done === 1'b1) break;
            tx_data  = (bi < FB) ? frame[bi] : 8'hFF;
            tx_valid = 1'b1;
            if (bi == 1 && tx_ready && stall_left > 0) begin
                tx_valid = 1'b0;
                stall_left--;
                if (SCK !== 1'b0 || SS !== 1'b0) stall_bad++;
            end
            hs = tx_ready && tx_valid;
        end
        start    = 1'b0;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SS !== 1'b1) begin errors++; $display("FAIL reset_ss: got %b want 1", SS); end
        checks++; if (SCK !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", SCK); end
        checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL reset_digit: got %h want 0", digit); end
        checks++; if (cost !== 8'h00) begin errors++; $display("FAIL reset_cost: got %h want 00", cost); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame();
        int cyc, sb, d0;
        logic [3:0] sd;
        logic [7:0] sc;
        d0 = done_cnt;
        run_txn(4'd7, 8'h03, 8'h1E, 0, 0, 0, 0, cyc, sb, sd, sc);
        repeat (6) @(negedge clk);
        checks++; if (cyc != 175) begin errors++; $display("FAIL frame_cycles: got %0d want 175", cyc); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL frame_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (nbits != 40) begin errors++; $display("FAIL frame_nbits: got %0d want 40", nbits); end
        checks++; if (mosi_bits[39:0] !== 40'hA53C070000) begin errors++; $display("FAIL frame_mosi: got %h want a53c070000", mosi_bits[39:0]); end
        checks++; if (digit !== 4'd3) begin errors++; $display("FAIL frame_digit: got %h want 3", digit); end
        checks++; if (cost !== 8'h1E) begin errors++; $display("FAIL frame_cost: got %h want 1e", cost); end
        checks++; if (busy !== 1'b0 || SS !== 1'b1) begin errors++; $display("FAIL frame_idle: got busy=%b ss=%b want 0/1", busy, SS); end
    endtask

    task automatic test_stall();
        int cyc, sb;
        logic [3:0] sd;
        logic [7:0] sc;
        run_txn(4'd7, 8'hA8, 8'h42, 20, 0, 0, 0, cyc, sb, sd, sc);
        repeat (6) @(negedge clk);
        checks++; if (cyc != 195) begin errors++; $display("FAIL stall_cycles: got %0d want 195", cyc); end
        checks++; if (sb != 0) begin errors++; $display("FAIL stall_bus_idle: got %0d bad cycles want 0", sb); end
        checks++; if (mosi_bits[39:0] !== 40'hA53C070000) begin errors++; $display("FAIL stall_mosi: got %h want a53c070000", mosi_bits[39:0]); end
        checks++; if (digit !== 4'd8 || cost !== 8'h42) begin errors++; $display("FAIL stall_resp: got %h/%h want 8/42", digit, cost); end
    endtask

    task automatic test_start_busy();
        int cyc, sb, d0;
        logic [3:0] sd;
        logic [7:0] sc;
        d0 = done_cnt;
        run_txn(4'd7, 8'h03, 8'h1E, 0, 10, 0, 0, cyc, sb, sd, sc);
        repeat (20) @(negedge clk);
        checks++; if (cyc != 175) begin errors++; $display("FAIL busy_cycles: got %0d want 175", cyc); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (mosi_bits[39:0] !== 40'hA53C070000) begin errors++; $display("FAIL busy_label_mosi: got %h want a53c070000", mosi_bits[39:0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart: got %b want 0", busy); end
    endtask

    task automatic test_no_cost();
        int cyc, sb;
        logic [3:0] sd;
        logic [7:0] sc;
        run_txn(NO_LABEL, 8'h09, 8'h5A, 0, 0, 0, 150, cyc, sb, sd, sc);
        repeat (6) @(negedge clk);
        checks++; if (sd !== 4'd3 || sc !== 8'h1E) begin errors++; $display("FAIL nocost_hold: got %h/%h want 3/1e", sd, sc); end
        checks++; if (mosi_bits[39:0] !== 40'hA53C0F0000) begin errors++; $display("FAIL nocost_mosi: got %h want a53c0f0000", mosi_bits[39:0]); end
        checks++; if (digit !== 4'd9 || cost !== 8'h5A) begin errors++; $display("FAIL nocost_resp: got %h/%h want 9/5a", digit, cost); end
    endtask

    task automatic test_reset_mid();
        int cyc, sb;
        logic [3:0] sd;
        logic [7:0] sc;
        run_txn(4'd7, 8'h03, 8'h1E, 0, 0, 103, 0, cyc, sb, sd, sc);
        checks++; if (busy !== 1'b1 || SS !== 1'b0) begin errors++; $display("FAIL rstmid_in_wait: got busy=%b ss=%b want 1/0", busy, SS); end
        n_rst = 1'b0;
        start = 1'b0;
        tx_valid = 1'b0;
        #1;
        checks++; if (SS !== 1'b1 || SCK !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_bus: got ss=%b sck=%b busy=%b want 1/0/0", SS, SCK, busy); end
        checks++; if (digit !== 4'h0 || cost !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: got %h/%h want 0/00", digit, cost); end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run_txn(4'd2, 8'h05, 8'h80, 0, 0, 0, 0, cyc, sb, sd, sc);
        repeat (6) @(negedge clk);
        checks++; if (cyc != 175) begin errors++; $display("FAIL rstmid_cycles: got %0d want 175", cyc); end
        checks++; if (mosi_bits[39:0] !== 40'hA53C020000) begin errors++; $display("FAIL rstmid_mosi: got %h want a53c020000", mosi_bits[39:0]); end
        checks++; if (digit !== 4'd5 || cost !== 8'h80) begin errors++; $display("FAIL rstmid_resp: got %h/%h want 5/80", digit, cost); end
    endtask

    task automatic test_mode0();
        checks++; if (rise_total < 200) begin errors++; $display("FAIL mode0_activity: got %0d sck rises want >=200", rise_total); end
        checks++; if (mode0_bad != 0) begin errors++; $display("FAIL mode0_mosi_stable: got %0d changes while sck high want 0", mode0_bad); end
    endtask

    initial begin
        n_rst    = 1'b0;
        start    = 1'b0;
        label    = 4'h0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        test_reset();
        test_frame();
        test_stall();
        test_start_busy();
        test_no_cost();
        test_reset_mid();
        test_mode0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_image_host.md
# spi_image_host

SPI master that drives the digit recognizer from the host side of the board. It streams one image frame of pixel bytes over SCK/SS/MOSI, then the expected-label byte. After a fixed compute wait it clocks in two response bytes on MISO, the detected digit and the cost. It sits in the host/FPGA test harness opposite the recognizer's SPI input and output controllers.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period (≥1)
- FRAME_BYTES, 98: pixel bytes per frame (≥1)
- WAIT_CYCLES, 2048: clk cycles between the label byte and the response bytes, with SS held low

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin a transaction; honoured only in IDLE
- label  in  4  expected digit, latched on an accepted start; 4'hF means no cost requested
- tx_data  in  8  pixel byte stream
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted when tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse at the end of a transaction
- digit  out  4  detected digit, from response byte 0 bits [3:0]
- cost  out  8  response byte 1
- SCK  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- SS  out  1  active-low slave select
- MOSI  out  1  serial data, MSB first
- MISO  in  1  serial data from the recognizer

## Operation
- Reset values: SS=1, SCK=0, MOSI=0, tx_ready=0, busy=0, done=0, digit=0, cost=0, state IDLE. Reset mid-transaction returns all outputs to these values immediately. No partial byte is resumed.
- States: IDLE → FETCH → XFER → (FETCH | LABEL) → WAIT → RESP → GAP → IDLE.
- IDLE → FETCH on start. Latch label and clear byte_cnt. SS falls on the same transition.
- FETCH: tx_ready=1. On handshake, load the shift register and go to XFER. If tx_valid is low, stay: SCK low, SS low, bus stretched indefinitely.
- XFER: shifts 8 bits. Then byte_cnt++. If byte_cnt==FRAME_BYTES go to LABEL, else go to FETCH.
- LABEL: shifts {4'h0, label}, then goes to WAIT.
- WAIT: SCK low, SS low, MOSI=0 for WAIT_CYCLES cycles, then RESP.
- RESP: shifts two 8'h00 bytes out. Captures MISO into byte 0, then byte 1. On the final bit, digit=byte0[3:0] and cost=byte1, registered together. Go to GAP.
- GAP: SS=1 for 2*CLK_DIV cycles. done pulses on the last GAP cycle, then IDLE.
- start while busy is ignored. tx_valid outside FETCH is ignored.
- digit and cost hold until the next completed transaction. They are not cleared by start.

## Timing
- Bit cell is 2*CLK_DIV cycles: SCK low for CLK_DIV, then high for CLK_DIV.
- MOSI changes only while SCK is low, on the cycle SCK falls or on the cycle a byte is loaded.
- MISO is sampled into the shift register on the clk edge where SCK rises.
- First MOSI bit is valid when its byte is loaded. The first SCK rise follows CLK_DIV cycles later.
- The FETCH handshake costs exactly 1 cycle between bytes when tx_valid is already high.
- The label byte and the RESP bytes follow back-to-back with no FETCH cycle.
- Transaction length with no stalls: FRAME_BYTES*(16*CLK_DIV+1) + 16*CLK_DIV + WAIT_CYCLES + 32*CLK_DIV + 2*CLK_DIV + 1 cycles, from start to done.
- Divider counter width is $clog2(CLK_DIV)+1. byte_cnt width is $clog2(FRAME_BYTES+1). No wrap is reachable.

## Structure
- Package spi_host_pkg holds:
  - state enum (IDLE, FETCH, XFER, LABEL, WAIT, RESP, GAP)
  - RESP_BYTES=2
  - NO_LABEL=4'hF
  - BYTE_W=8
- One sub-module, spi_byte_shifter, owns the SCK divider, the 8-bit TX/RX shift registers and the bit counter.
  - Ports: load, tx_byte, go, byte_done pulse, rx_byte.
- The top level holds the FSM, byte_cnt, the wait counter and the output registers.

## Test plan
1. Frame streaming: CLK_DIV=2, FRAME_BYTES=2, WAIT_CYCLES=8, tx bytes 8'hA5, 8'h3C always valid, label=4'd7, MISO model returns 8'h03, 8'h1E.
   - MOSI bit sequence 10100101 00111100 00000111 then 16 zeros.
   - digit=3, cost=8'h1E, one done pulse.
   - Total cycles to done = 2*33+32+8+64+4+1 = 175.
2. tx stall: tx_valid dropped for 20 cycles before byte 2.
   - SCK stays low and SS stays low for the whole stall.
   - Total cycles = 195.
   - MOSI bit sequence identical to test 1.
3. start while busy: pulse start mid-XFER.
   - No effect on the current transaction.
   - Exactly one done pulse.
   - label still equals the first latched value on MOSI.
4. Reset mid-transaction: assert n_rst low during WAIT.
   - SS=1, SCK=0, busy=0 and digit/cost=0 immediately.
   - A subsequent start runs a full, correct transaction.
5. No-cost label: label=4'hF.
   - Label byte 8'h0F appears on MOSI.
   - cost still captured from MISO.
   - Previous digit/cost held until the new done pulse.
6. Mode-0 check: a bench monitor samples MOSI on every SCK rise and asserts that MOSI never changes while SCK=1.
